// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: widths, segment patterns, buffer type.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package seg7_scan_ctrl_pkg;

  // Producer bus geometry: six hex nibbles plus one decimal point per digit.
  localparam int DATA_W = 24;
  localparam int DP_W   = 6;

  // Digit index width; sel is binary and covers up to eight digits.
  localparam int IDX_W = 3;

  // All segments dark (outputs are active-low).
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low g..a patterns, entry n is hex digit n (listed F down to 0).
  localparam logic [15:0][6:0] HEX_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // One display buffer: the value a whole frame is drawn from.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DP_W-1:0]   dp;
  } disp_t;

  function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
    return HEX_TAB[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Producer-to-display data bus with valid/ready handshake.
// Latency: none (wiring only).
// Backpressure: the display side holds data_rdy low while its pending buffer is occupied.
interface seg7_scan_ctrl_if;
  import seg7_scan_ctrl_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic [DP_W-1:0]   dp_in;
  logic              data_vld;
  logic              data_rdy;

  // Producer side.
  modport master (
    output data_in,
    output dp_in,
    output data_vld,
    input  data_rdy
  );

  // Display controller side.
  modport slave (
    input  data_in,
    input  dp_in,
    input  data_vld,
    output data_rdy
  );

endinterface

// File: rtl/seg7_hex_dec.sv
// Hex nibble to active-low 7-segment pattern (g..a).
// Latency: combinational.
// Backpressure: not applicable.
module seg7_hex_dec
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  assign pat = hex_pattern(nib);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: digit sequencing, brightness PWM, guard time, double buffer.
// Latency: seg/sel/frame_done registered, one cycle behind the prescaler and digit index.
// Backpressure: data_rdy low while the pending buffer holds a value not yet promoted at a frame boundary.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIG  = 6,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 500
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_ctrl_if.slave  bus,
  input  logic             blank_lz,
  input  logic [2:0]       bright,
  output logic [7:0]       seg,
  output logic [IDX_W-1:0] sel,
  output logic             frame_done
);

  // Prescaler width, and a wider width for the brightness window so that
  // (bright+1)*(SCAN_DIV/8) never truncates, even at bright=7 where it equals SCAN_DIV.
  localparam int PC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int WIN_W = (PC_W + 4 > 17) ? PC_W + 4 : 17;

  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);
  localparam logic [WIN_W-1:0] SLOT8    = WIN_W'(SCAN_DIV / 8);
  localparam logic [WIN_W-1:0] GUARD_W  = WIN_W'(GUARD);

  logic [PC_W-1:0]  pc;
  logic [IDX_W-1:0] idx;
  disp_t            act;
  disp_t            pend;
  logic             pend_full;

  logic             slot_end;
  logic             frame_end;
  logic             xfer;

  logic [WIN_W-1:0] pc_w;
  logic [WIN_W-1:0] win_end;
  logic             lit;

  logic [3:0]       cur_nib;
  logic             cur_dp;
  logic             cur_blank;
  logic             zero_run;
  logic [6:0]       cur_pat;

  assign slot_end  = (pc == PC_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Ready is simply "pending slot free", so a new transfer can never collide
  // with the frame-boundary promotion of the pending value.
  assign bus.data_rdy = !pend_full;
  assign xfer         = bus.data_vld && !pend_full;

  // Lit window: dark for the guard time at slot start, then lit up to the brightness limit.
  always_comb begin
    pc_w    = WIN_W'(pc);
    win_end = (WIN_W'(bright) + WIN_W'(1)) * SLOT8;
    lit     = (pc_w >= GUARD_W) && (pc_w < win_end);
  end

  // Pick the current digit from the active buffer and decide leading-zero blanking;
  // zero_run tracks "this nibble and every higher one is zero", walking from the MSD down.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    zero_run  = 1'b1;
    for (int k = NUM_DIG - 1; k >= 0; k--) begin
      zero_run = zero_run && (act.data[4*k +: 4] == 4'h0);
      if (IDX_W'(k) == idx) begin
        cur_nib   = act.data[4*k +: 4];
        cur_dp    = act.dp[k];
        cur_blank = blank_lz && (k != 0) && zero_run;
      end
    end
  end

  seg7_hex_dec u_hex_dec (
    .nib (cur_nib),
    .pat (cur_pat)
  );

  // Slot prescaler and digit index; the index advances only when a slot expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      idx <= '0;
    end else if (slot_end) begin
      pc  <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pc  <= pc + 1'b1;
    end
  end

  // Double buffer: accept into pending, promote to active only at the frame boundary
  // so a frame is always drawn from one consistent value.
  always_ff @(posedge clk) begin
    if (rst) begin
      act       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (xfer) begin
      pend      <= {bus.data_in, bus.dp_in};
      pend_full <= 1'b1;
    end else if (frame_end && pend_full) begin
      act       <= pend;
      pend_full <= 1'b0;
    end
  end

  // Output registers; sel is delayed with seg so pins switch digit and pattern on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_OFF;
      sel        <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= (lit && !cur_blank) ? {~cur_dp, cur_pat} : SEG_OFF;
      sel        <= idx;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a short scan period (80 clocks/slot, 4-clock guard).
// Latency: bench tracks its own cycle count k since reset; output at k reflects prescaler value k-1.
// Backpressure: exercised by holding data_vld high across two back-to-back values.
module tb_seg7_scan_ctrl;

  localparam int NUM_DIG  = 6;
  localparam int SCAN_DIV = 80;
  localparam int GUARD    = 4;
  localparam int FRAME    = NUM_DIG * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blank_lz = 1'b0;
  logic [2:0] bright = 3'd7;
  logic [7:0] seg;
  logic [2:0] sel;
  logic       frame_done;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .NUM_DIG  (NUM_DIG),
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .blank_lz   (blank_lz),
    .bright     (bright),
    .seg        (seg),
    .sel        (sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: number of non-reset edges since reset was released.
  int k;
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [23:0] data;
    logic [5:0]  dp;
    logic        blz;
    logic [2:0]  br;
    int          dig;
    int          opc;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic int opc_of(input int kk);
    return (kk - 1) % SCAN_DIV;
  endfunction

  function automatic int dig_of(input int kk);
    return ((kk - 1) / SCAN_DIV) % NUM_DIG;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, got, exp, k);
    end
  endtask

  // Advance to the next output cycle showing digit d at prescaler value o.
  task automatic wait_out(input int d, input int o);
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge clk);
      if (k >= 1 && dig_of(k) == d && opc_of(k) == o) begin
        check("sel_at_target", 32'(sel), 32'(d));
        return;
      end
    end
    check("wait_out_timeout", 0, 1);
  endtask

  // Advance to the first output cycle of a frame that starts strictly after any load just made.
  task automatic wait_frame_start();
    repeat (2) @(negedge clk);
    for (int n = 0; n < 2 * FRAME; n++) begin
      if ((k - 1) % FRAME == 0) return;
      @(negedge clk);
    end
    check("frame_start_timeout", 0, 1);
  endtask

  task automatic load(input logic [23:0] d, input logic [5:0] p);
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(negedge clk);
      if (bus.data_rdy === 1'b1) begin
        bus.data_in  = d;
        bus.dp_in    = p;
        bus.data_vld = 1'b1;
        @(negedge clk);
        check("rdy_after_load", 32'(bus.data_rdy), 0);
        bus.data_vld = 1'b0;
        return;
      end
    end
    check("load_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at k=%0d", k);
    $fatal(1);
  end

  initial begin
    logic [23:0] cur_d;
    logic [5:0]  cur_p;
    bit          have;
    int          fd_cnt;
    int          stall;
    int          fd_k;

    bus.data_in  = '0;
    bus.dp_in    = '0;
    bus.data_vld = 1'b0;

    // Display vectors: {data, dp, blank_lz, bright, digit, prescaler, expected seg}.
    vecs.push_back('{24'h123456, 6'b000100, 1'b0, 3'd7, 0, 40, 8'h82});
    vecs.push_back('{24'h123456, 6'b000100, 1'b0, 3'd7, 1,  3, 8'hFF});
    vecs.push_back('{24'h123456, 6'b000100, 1'b0, 3'd7, 1,  4, 8'h92});
    vecs.push_back('{24'h123456, 6'b000100, 1'b0, 3'd7, 2, 40, 8'h19});
    vecs.push_back('{24'h123456, 6'b000100, 1'b0, 3'd7, 5, 79, 8'hF9});
    vecs.push_back('{24'h123456, 6'b000100, 1'b0, 3'd0, 0,  9, 8'h82});
    vecs.push_back('{24'h123456, 6'b000100, 1'b0, 3'd0, 0, 10, 8'hFF});
    vecs.push_back('{24'h123456, 6'b000100, 1'b0, 3'd0, 3,  4, 8'hB0});
    vecs.push_back('{24'h123456, 6'b000100, 1'b0, 3'd3, 4, 39, 8'hA4});
    vecs.push_back('{24'h123456, 6'b000100, 1'b0, 3'd3, 4, 40, 8'hFF});
    vecs.push_back('{24'h123456, 6'b000100, 1'b1, 3'd7, 5, 50, 8'hF9});
    vecs.push_back('{24'h000070, 6'b000000, 1'b1, 3'd7, 0, 50, 8'hC0});
    vecs.push_back('{24'h000070, 6'b000000, 1'b1, 3'd7, 1, 50, 8'hF8});
    vecs.push_back('{24'h000070, 6'b000000, 1'b1, 3'd7, 2, 50, 8'hFF});
    vecs.push_back('{24'h000070, 6'b000000, 1'b1, 3'd7, 3, 50, 8'hFF});
    vecs.push_back('{24'h000070, 6'b000000, 1'b1, 3'd7, 5, 50, 8'hFF});
    vecs.push_back('{24'h000070, 6'b000000, 1'b0, 3'd7, 2, 50, 8'hC0});
    vecs.push_back('{24'h000070, 6'b000000, 1'b0, 3'd7, 5, 50, 8'hC0});
    vecs.push_back('{24'h000070, 6'b111111, 1'b1, 3'd7, 0, 50, 8'h40});
    vecs.push_back('{24'h000070, 6'b111111, 1'b1, 3'd7, 1, 50, 8'h78});
    vecs.push_back('{24'h000070, 6'b111111, 1'b1, 3'd7, 4, 50, 8'hFF});
    vecs.push_back('{24'h000070, 6'b111111, 1'b0, 3'd7, 4, 50, 8'h40});
    vecs.push_back('{24'h0A0000, 6'b000000, 1'b1, 3'd7, 0, 50, 8'hC0});
    vecs.push_back('{24'h0A0000, 6'b000000, 1'b1, 3'd7, 3, 50, 8'hC0});
    vecs.push_back('{24'h0A0000, 6'b000000, 1'b1, 3'd7, 4, 50, 8'h88});
    vecs.push_back('{24'h0A0000, 6'b000000, 1'b1, 3'd7, 5, 50, 8'hFF});
    vecs.push_back('{24'hEFBCD9, 6'b000000, 1'b0, 3'd7, 0, 20, 8'h90});
    vecs.push_back('{24'hEFBCD9, 6'b000000, 1'b0, 3'd7, 1, 20, 8'hA1});
    vecs.push_back('{24'hEFBCD9, 6'b000000, 1'b0, 3'd7, 2, 20, 8'hC6});
    vecs.push_back('{24'hEFBCD9, 6'b000000, 1'b0, 3'd7, 3, 20, 8'h83});
    vecs.push_back('{24'hEFBCD9, 6'b000000, 1'b0, 3'd7, 4, 20, 8'h8E});
    vecs.push_back('{24'hEFBCD9, 6'b000000, 1'b0, 3'd7, 5, 20, 8'h86});
    vecs.push_back('{24'h876543, 6'b000000, 1'b0, 3'd7, 0, 20, 8'hB0});
    vecs.push_back('{24'h876543, 6'b000000, 1'b0, 3'd7, 1, 20, 8'h99});
    vecs.push_back('{24'h876543, 6'b000000, 1'b0, 3'd7, 2, 20, 8'h92});
    vecs.push_back('{24'h876543, 6'b000000, 1'b0, 3'd7, 3, 20, 8'h82});
    vecs.push_back('{24'h876543, 6'b000000, 1'b0, 3'd7, 4, 20, 8'hF8});
    vecs.push_back('{24'h876543, 6'b000000, 1'b0, 3'd7, 5, 20, 8'h80});

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_sel", 32'(sel), 0);
    check("reset_rdy", 32'(bus.data_rdy), 1);
    check("reset_frame_done", 32'(frame_done), 0);
    rst = 1'b0;

    // Table-driven display vectors; reload the buffer whenever the data changes.
    have  = 1'b0;
    cur_d = '0;
    cur_p = '0;
    foreach (vecs[i]) begin
      if (!have || vecs[i].data !== cur_d || vecs[i].dp !== cur_p) begin
        load(vecs[i].data, vecs[i].dp);
        wait_frame_start();
        cur_d = vecs[i].data;
        cur_p = vecs[i].dp;
        have  = 1'b1;
      end
      blank_lz = vecs[i].blz;
      bright   = vecs[i].br;
      wait_out(vecs[i].dig, vecs[i].opc);
      check($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].exp));
    end

    // Scan timing and brightness windows, cycle by cycle over whole frames (876543 still active).
    blank_lz = 1'b0;
    bright   = 3'd0;
    wait_frame_start();
    fd_cnt = 0;
    for (int n = 0; n < 3 * FRAME; n++) begin
      if (n == 2 * FRAME) bright = 3'd3;
      @(negedge clk);
      if (frame_done === 1'b1) fd_cnt++;
      check("scan_sel", 32'(sel), 32'(dig_of(k)));
      check("scan_frame_done", 32'(frame_done), 32'(k % FRAME == 0));
      if (n >= 2 * FRAME)
        check("lit_bright3", 32'(seg !== 8'hFF), 32'(opc_of(k) >= 4 && opc_of(k) < 40));
      else
        check("lit_bright0", 32'(seg !== 8'hFF), 32'(opc_of(k) >= 4 && opc_of(k) < 10));
    end
    check("frame_done_count", 32'(fd_cnt), 3);

    // Backpressure: second value stalls until the first is promoted at a frame boundary.
    bright = 3'd7;
    for (int n = 0; n < 3 * FRAME && bus.data_rdy !== 1'b1; n++) @(negedge clk);
    bus.data_in  = 24'h111111;
    bus.dp_in    = 6'b000000;
    bus.data_vld = 1'b1;
    @(negedge clk);
    check("bp_first_taken", 32'(bus.data_rdy), 0);
    bus.data_in = 24'h222222;
    stall = 0;
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(negedge clk);
      if (bus.data_rdy === 1'b1) break;
      stall++;
    end
    check("bp_rdy_at_boundary", 32'(bus.data_rdy === 1'b1 && k % FRAME == 0), 1);
    @(negedge clk);
    check("bp_second_taken", 32'(bus.data_rdy), 0);
    bus.data_vld = 1'b0;
    wait_out(0, 40);
    check("bp_first_shown_d0", 32'(seg), 32'hF9);
    wait_out(5, 40);
    check("bp_first_shown_d5", 32'(seg), 32'hF9);
    wait_out(0, 40);
    check("bp_second_shown", 32'(seg), 32'hA4);

    // Reset mid-frame with a value waiting in pending: both buffers and outputs clear.
    load(24'h999999, 6'b111111);
    wait_out(3, 40);
    check("pre_reset_seg", 32'(seg), 32'hA4);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_seg", 32'(seg), 32'hFF);
    check("midreset_sel", 32'(sel), 0);
    check("midreset_rdy", 32'(bus.data_rdy), 1);
    check("midreset_frame_done", 32'(frame_done), 0);
    rst = 1'b0;
    fd_k = -1;
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        fd_k = k;
        break;
      end
    end
    check("post_reset_first_frame_done", 32'(fd_k), 32'(FRAME));
    blank_lz = 1'b1;
    wait_out(0, 40);
    check("post_reset_d0", 32'(seg), 32'hC0);
    wait_out(3, 40);
    check("post_reset_d3_blank", 32'(seg), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
